int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Programmable interrupt controller between the six raw interrupt sources (Timer0 IRQ, Timer1 IRQ, external interrupt, three spare) and CP0's HWInt input.
- Adds per-source masking, edge/level mode, sticky pending bits and fixed-priority nesting with claim/EOI.
- Memory-mapped at 0x7F30–0x7F3F; the Bridge decodes the range and supplies the word address and write enable.

Parameters:
- NUM_SRC, 6, number of interrupt sources (max 7; id 7 means "none").

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- addr  in  [31:2]  word address from Bridge; only addr[3:2] decoded
- we  in  1  register write strobe; Bridge asserts it only for byteen==4'b1111 inside 0x7F30–0x7F3F
- din  in  32  write data
- dout  out  32  read data (combinational from addr[3:2])
- src  in  NUM_SRC  raw sources, synchronous to clk, index 0 = highest priority
- irq  out  1  interrupt request to CP0 (HWInt bit)
- irq_id  out  3  index of the source irq refers to; 7 when irq=0

Behaviour:
- Registers, selected by addr[3:2]:
  - 0 STATUS: read {26'b0, pend}. Write: 1 clears pend bit (W1C), edge-mode bits only.
  - 1 MASK: RW [5:0], 1 = enabled.
  - 2 MODE: RW [5:0], 1 = edge, 0 = level.
  - 3 CTRL:
    - Read {irq, 28'b0, irq_id}.
    - Write with din[3]=0: CLAIM id din[2:0].
    - Write with din[3]=1: EOI.
- Reset (async, reset=0):
  - pend, mask, mode, isr, src_q all 0.
  - irq=0, irq_id=7, dout depends only on addr.
  - Reset mid-operation discards all pending and in-service state immediately.
- Edge mode:
  - src_q registers src every cycle.
  - At the clock edge where src[i]=1 and src_q[i]=0, pend[i] is set.
  - pend[i] is cleared by W1C or by a successful CLAIM.
  - Set and clear in the same cycle: set wins.
- Level mode:
  - pend[i] is the registered copy of src[i], updated every cycle.
  - W1C and CLAIM do not affect pend[i].
- Candidate selection:
  - cand = lowest i with pend[i]&mask[i].
  - top = lowest i with isr[i]; 7 if isr=0.
- Outputs:
  - irq = cand exists AND cand < top.
  - irq_id = cand when irq=1, else 7.
  - Both are combinational from registers, so the first cycle irq can be high is the cycle after the capturing edge (latency 1 clk from src rise).
- CLAIM k:
  - Valid only if k<NUM_SRC and pend[k]&mask[k].
  - On a valid claim: set isr[k]; clear pend[k] if edge mode.
  - Otherwise no state change.
- EOI: clear the lowest set bit of isr. No-op if isr=0.
- Nesting: a higher-priority source may assert irq while a lower one is in service. Equal or lower priority is held off until EOI.
- MASK write clearing a bit only suppresses irq; pend is retained.
- Reads have no side effects. Bits [31:6] of MASK/MODE writes are ignored.

Decomposition:
- Shared package/constants file:
  - Register offsets: INTC_STATUS=2'd0, INTC_MASK=2'd1, INTC_MODE=2'd2, INTC_CTRL=2'd3.
  - Base address 32'h7F30.
  - NUM_SRC default.
  - INTC_NONE=3'd7.
- One sub-module: intc_prio_enc, a lowest-index-first priority encoder (vector in, {valid, id} out). Instantiated twice, for cand and top.

Test Plan:
- Reset then read all offsets -> STATUS=0, MASK=0, MODE=0, CTRL=32'h7, irq=0; assert reset mid-claim -> all state 0 within the same cycle.
- MODE=6'h3F, MASK=6'h01, pulse src[0] one cycle -> irq=1, irq_id=0 the next cycle; CLAIM 0 -> irq=0, STATUS=0; EOI -> isr empty.
- Claim src2, then pulse src0 -> irq=1, id=0 (preempts); pulse src4 while src2 in service -> irq stays 0 until two EOIs, then id=4.
- MASK=0, pulse src1 -> STATUS=6'h02, irq=0; write MASK=6'h02 -> irq=1, id=1; W1C 6'h02 -> irq=0.
- Level mode src3 held high, MASK=6'h08 -> irq=1, id=3; W1C ignored; CLAIM 3 -> irq=0; EOI with src3 still high -> irq=1 again; drop src3 -> irq=0 one cycle later.
- Edge on src5 in the same cycle as W1C 6'h20 -> pend[5]=1 (set wins); CLAIM 6 and CLAIM of non-pending id -> no change.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared constants and types for the int_ctrl programmable interrupt controller.
package int_ctrl_pkg;

  localparam int unsigned NUM_SRC_DEF = 6;
  localparam int unsigned ID_W        = 3;
  localparam logic [31:0] INTC_BASE   = 32'h7F30;
  localparam logic [ID_W-1:0] INTC_NONE = 3'd7;

  typedef enum logic [1:0] {
    INTC_STATUS = 2'd0,
    INTC_MASK   = 2'd1,
    INTC_MODE   = 2'd2,
    INTC_CTRL   = 2'd3
  } intc_reg_e;

  // Read view of the CTRL register.
  typedef struct packed {
    logic            irq;
    logic [27:0]     rsvd;
    logic [ID_W-1:0] id;
  } intc_ctrl_rd_t;

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-first priority encoder; id is INTC_NONE when no bit is set.
module intc_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int unsigned W = NUM_SRC_DEF
) (
  input  logic [W-1:0]    vec_i,
  output logic            valid_o,
  output logic [ID_W-1:0] id_o
);

  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    valid_o = 1'b0;
    id_o    = INTC_NONE;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        valid_o = 1'b1;
        id_o    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Programmable interrupt controller: masking, edge/level pending, fixed-priority
// nesting with claim/EOI, feeding one CP0 HWInt line.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:2]        addr,
  input  logic               we,
  input  logic [31:0]        din,
  output logic [31:0]        dout,
  input  logic [NUM_SRC-1:0] src,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id
);

  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] isr_q,  isr_d;
  logic [NUM_SRC-1:0] src_q;

  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] claim_oh;
  logic [NUM_SRC-1:0] rise;
  logic               claim_req;

  logic               cand_valid;
  logic [ID_W-1:0]    cand_id;
  logic               top_valid;
  logic [ID_W-1:0]    top_id;

  intc_reg_e          reg_sel;
  intc_ctrl_rd_t      ctrl_rd;
  logic               unused_bits;

  assign reg_sel     = intc_reg_e'(addr[3:2]);
  assign rise        = src & ~src_q;
  assign unused_bits = ^{addr[31:4], din[31:NUM_SRC], top_valid};

  intc_prio_enc #(.W(NUM_SRC)) u_cand_enc (
    .vec_i   (pend_q & mask_q),
    .valid_o (cand_valid),
    .id_o    (cand_id)
  );

  intc_prio_enc #(.W(NUM_SRC)) u_top_enc (
    .vec_i   (isr_q),
    .valid_o (top_valid),
    .id_o    (top_id)
  );

  // top_id is INTC_NONE when nothing is in service, so any candidate wins then.
  assign irq    = cand_valid && (cand_id < top_id);
  assign irq_id = irq ? cand_id : INTC_NONE;

  // Register writes, claim/EOI and pending update.
  always_comb begin
    mask_d    = mask_q;
    mode_d    = mode_q;
    isr_d     = isr_q;
    w1c       = '0;
    claim_req = 1'b0;
    claim_oh  = '0;

    if (we) begin
      case (reg_sel)
        INTC_STATUS: w1c    = din[NUM_SRC-1:0];
        INTC_MASK:   mask_d = din[NUM_SRC-1:0];
        INTC_MODE:   mode_d = din[NUM_SRC-1:0];
        INTC_CTRL: begin
          if (din[3]) begin
            isr_d = isr_q & (isr_q - NUM_SRC'(1));
          end else begin
            claim_req = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Out-of-range ids shift out to zero and so never claim anything.
    if (claim_req) begin
      claim_oh = (NUM_SRC'(1) << din[2:0]) & pend_q & mask_q;
    end
    isr_d = isr_d | claim_oh;

    pend_d = (mode_q & ((pend_q & ~(w1c | claim_oh)) | rise))
           | (~mode_q & src);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
      mask_q <= '0;
      mode_q <= '0;
      isr_q  <= '0;
      src_q  <= '0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
      mode_q <= mode_d;
      isr_q  <= isr_d;
      src_q  <= src;
    end
  end

  // Side-effect-free read mux.
  always_comb begin
    ctrl_rd = '{irq: irq, rsvd: '0, id: irq_id};
    dout    = '0;
    case (reg_sel)
      INTC_STATUS: dout = 32'(pend_q);
      INTC_MASK:   dout = 32'(mask_q);
      INTC_MODE:   dout = 32'(mode_q);
      INTC_CTRL:   dout = ctrl_rd;
      default:     dout = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl.
module tb_int_ctrl;

  logic        clk;
  logic        reset;
  logic [31:2] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic [5:0]  src;
  logic        irq;
  logic [2:0]  irq_id;

  int n_cmp = 0;
  int n_err = 0;

  int_ctrl #(.NUM_SRC(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .din    (din),
    .dout   (dout),
    .src    (src),
    .irq    (irq),
    .irq_id (irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] data);
    addr = {26'h0, 2'b11, off} + 30'(32'h7F30 >> 2) - 30'h0C - 30'(off) + 30'(off);
    addr[3:2] = off;
    din  = data;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
    din  = '0;
  endtask

  task automatic rd(input logic [1:0] off, output logic [31:0] data);
    addr = 30'(32'h7F30 >> 2);
    addr[3:2] = off;
    #1;
    data = dout;
  endtask

  task automatic pulse(input logic [5:0] v);
    src = v;
    @(posedge clk);
    #1;
    src = '0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b0;
    tick(2);
    rd(2'd0, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h want %h", d, 32'h0); end
    rd(2'd1, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_mask: got %h want %h", d, 32'h0); end
    rd(2'd2, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_mode: got %h want %h", d, 32'h0); end
    rd(2'd3, d);
    n_cmp++; if (d !== 32'h7) begin n_err++; $display("FAIL reset_ctrl: got %h want %h", d, 32'h7); end
    n_cmp++; if (irq !== 1'b0 || irq_id !== 3'd7) begin n_err++; $display("FAIL reset_irq: got %b/%0d want 0/7", irq, irq_id); end
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_edge_basic;
    logic [31:0] d;
    wr(2'd2, 32'h3F);
    wr(2'd1, 32'h01);
    rd(2'd1, d);
    n_cmp++; if (d !== 32'h01) begin n_err++; $display("FAIL mask_rb: got %h want %h", d, 32'h01); end
    pulse(6'h01);
    n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd0) begin n_err++; $display("FAIL edge_irq: got %b/%0d want 1/0", irq, irq_id); end
    rd(2'd3, d);
    n_cmp++; if (d !== 32'h8000_0000) begin n_err++; $display("FAIL edge_ctrl: got %h want %h", d, 32'h8000_0000); end
    wr(2'd3, 32'h0);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL claim0_irq: got %b want 0", irq); end
    rd(2'd0, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL claim0_status: got %h want %h", d, 32'h0); end
    wr(2'd3, 32'h8);
    pulse(6'h01);
    n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd0) begin n_err++; $display("FAIL eoi0_irq: got %b/%0d want 1/0", irq, irq_id); end
    wr(2'd0, 32'h01);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL w1c0_irq: got %b want 0", irq); end
  endtask

  task automatic test_nesting;
    logic [31:0] d;
    wr(2'd1, 32'h3F);
    pulse(6'h04);
    n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd2) begin n_err++; $display("FAIL nest_src2: got %b/%0d want 1/2", irq, irq_id); end
    wr(2'd3, 32'h2);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL nest_claim2: got %b want 0", irq); end
    pulse(6'h01);
    n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd0) begin n_err++; $display("FAIL nest_preempt: got %b/%0d want 1/0", irq, irq_id); end
    wr(2'd3, 32'h0);
    pulse(6'h10);
    n_cmp++; if (irq !== 1'b0 || irq_id !== 3'd7) begin n_err++; $display("FAIL nest_held: got %b/%0d want 0/7", irq, irq_id); end
    wr(2'd3, 32'h8);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL nest_eoi1: got %b want 0", irq); end
    wr(2'd3, 32'h8);
    n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd4) begin n_err++; $display("FAIL nest_eoi2: got %b/%0d want 1/4", irq, irq_id); end
    rd(2'd0, d);
    n_cmp++; if (d !== 32'h10) begin n_err++; $display("FAIL nest_status: got %h want %h", d, 32'h10); end
    wr(2'd0, 32'h10);
  endtask

  task automatic test_mask;
    logic [31:0] d;
    wr(2'd1, 32'h0);
    pulse(6'h02);
    rd(2'd0, d);
    n_cmp++; if (d !== 32'h02) begin n_err++; $display("FAIL mask_pend: got %h want %h", d, 32'h02); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mask_irq_off: got %b want 0", irq); end
    wr(2'd1, 32'hFFFF_FF02);
    rd(2'd1, d);
    n_cmp++; if (d !== 32'h02) begin n_err++; $display("FAIL mask_upper: got %h want %h", d, 32'h02); end
    n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd1) begin n_err++; $display("FAIL mask_irq_on: got %b/%0d want 1/1", irq, irq_id); end
    wr(2'd0, 32'h02);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mask_w1c: got %b want 0", irq); end
  endtask

  task automatic test_level;
    logic [31:0] d;
    wr(2'd2, 32'h37);
    wr(2'd1, 32'h08);
    src = 6'h08;
    tick(1);
    n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd3) begin n_err++; $display("FAIL lvl_irq: got %b/%0d want 1/3", irq, irq_id); end
    wr(2'd0, 32'h08);
    rd(2'd0, d);
    n_cmp++; if (d !== 32'h08) begin n_err++; $display("FAIL lvl_w1c: got %h want %h", d, 32'h08); end
    wr(2'd3, 32'h3);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL lvl_claim: got %b want 0", irq); end
    wr(2'd3, 32'h8);
    n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd3) begin n_err++; $display("FAIL lvl_eoi: got %b/%0d want 1/3", irq, irq_id); end
    src = 6'h00;
    #1;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL lvl_drop_same: got %b want 1", irq); end
    tick(1);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL lvl_drop_next: got %b want 0", irq); end
  endtask

  task automatic test_set_wins;
    logic [31:0] d;
    wr(2'd2, 32'h3F);
    wr(2'd1, 32'h3F);
    addr = 30'(32'h7F30 >> 2);
    din  = 32'h20;
    we   = 1'b1;
    src  = 6'h20;
    tick(1);
    we   = 1'b0;
    src  = 6'h00;
    rd(2'd0, d);
    n_cmp++; if (d !== 32'h20) begin n_err++; $display("FAIL setwins_status: got %h want %h", d, 32'h20); end
    n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd5) begin n_err++; $display("FAIL setwins_irq: got %b/%0d want 1/5", irq, irq_id); end
    wr(2'd3, 32'h6);
    rd(2'd0, d);
    n_cmp++; if (d !== 32'h20 || irq !== 1'b1 || irq_id !== 3'd5) begin n_err++; $display("FAIL claim6: got %h/%b/%0d want 20/1/5", d, irq, irq_id); end
    wr(2'd3, 32'h2);
    rd(2'd0, d);
    n_cmp++; if (d !== 32'h20 || irq !== 1'b1 || irq_id !== 3'd5) begin n_err++; $display("FAIL claim_nopend: got %h/%b/%0d want 20/1/5", d, irq, irq_id); end
    wr(2'd3, 32'h7);
    n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd5) begin n_err++; $display("FAIL claim7: got %b/%0d want 1/5", irq, irq_id); end
    wr(2'd0, 32'h20);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL setwins_clear: got %b want 0", irq); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    pulse(6'h02);
    wr(2'd3, 32'h1);
    pulse(6'h01);
    n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd0) begin n_err++; $display("FAIL mid_pre: got %b/%0d want 1/0", irq, irq_id); end
    reset = 1'b0;
    #1;
    n_cmp++; if (irq !== 1'b0 || irq_id !== 3'd7) begin n_err++; $display("FAIL mid_irq: got %b/%0d want 0/7", irq, irq_id); end
    rd(2'd0, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL mid_status: got %h want %h", d, 32'h0); end
    rd(2'd1, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL mid_mask: got %h want %h", d, 32'h0); end
    rd(2'd2, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL mid_mode: got %h want %h", d, 32'h0); end
    reset = 1'b1;
    tick(1);
    wr(2'd2, 32'h02);
    wr(2'd1, 32'h02);
    pulse(6'h02);
    n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd1) begin n_err++; $display("FAIL mid_isr_gone: got %b/%0d want 1/1", irq, irq_id); end
    rd(2'd0, d);
    n_cmp++; if (d !== 32'h02) begin n_err++; $display("FAIL mid_pend_gone: got %h want %h", d, 32'h02); end
  endtask

  initial begin
    reset = 1'b0;
    addr  = '0;
    we    = 1'b0;
    din   = '0;
    src   = '0;
    #2;
    test_reset;
    test_edge_basic;
    test_nesting;
    test_mask;
    test_level;
    test_set_wins;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
